seq_det_frame_ctrl: RTL and testbench

//  Frame scheduler for the "001" Mealy sequence detector. Accepts a W-bit word via valid/ready,

---
 rtl/seq_det_frame_ctrl_pkg.sv | 33 +++
 rtl/seq_det_frame_ctrl_if.sv | 17 +
 rtl/seq_det_001_core.sv | 33 +++
 rtl/seq_det_frame_ctrl.sv | 90 +++++++++
 tb/tb_seq_det_frame_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_frame_ctrl_pkg.sv
// Shared types for the "001" frame scheduler: frame FSM states, detector states, defaults.
// Latency: n/a (types and a pure next-state function only).
// Backpressure: n/a.
package seq_det_frame_ctrl_pkg;

  localparam int W_DEF  = 8;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } det_state_t;

  // Next state of the "001" detector; any 1 returns to S0, zeros walk S0->S1->S2 and stay in S2.
  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      S0:      n = b ? S0 : S1;
      S1:      n = b ? S0 : S2;
      S2:      n = b ? S0 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_det_frame_ctrl_if.sv
// Producer-side word handshake into the frame scheduler (valid/ready plus carry control).
// Latency: n/a (wires only).
// Backpressure: in_ready from the slave gates acceptance of in_data/carry_en.
interface seq_det_frame_ctrl_if
  import seq_det_frame_ctrl_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         carry_en;

  modport master (output in_valid, output in_data, output carry_en, input in_ready);
  modport slave  (input in_valid, input in_data, input carry_en, output in_ready);

endinterface

// File: rtl/seq_det_001_core.sv
// Three-state Mealy detector for the bit pattern "001", overlapping matches allowed.
// Latency: det is combinational on inp in the same cycle; state advances on the clock edge.
// Backpressure: none; state only moves when en is high, clr forces S0.
module seq_det_001_core
  import seq_det_frame_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic inp,
  output logic det
);

  det_state_t state;
  det_state_t state_nxt;

  // Detector state register: reset/clr win over the enabled advance.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= S0;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy output; a 1 arriving in S2 completes "001".
  always_comb begin
    state_nxt = det_next(state, inp);
    det       = en & inp & (state == S2);
  end

endmodule

// File: rtl/seq_det_frame_ctrl.sv
// Accepts a W-bit word, shifts it MSB-first through the "001" detector and counts hits per frame.
// Latency: W SHIFT cycles after accept, then one REPORT cycle with done; one frame per W+2 cycles.
// Backpressure: in_ready only in IDLE (and not in reset); in_valid is ignored in SHIFT/REPORT.
module seq_det_frame_ctrl
  import seq_det_frame_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  seq_det_frame_ctrl_if.slave in_bus,
  output logic                bit_out,
  output logic                det_out,
  output logic [CW-1:0]       cnt_out,
  output logic                done
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  frame_state_t  state;
  frame_state_t  state_nxt;
  logic [W-1:0]  shreg;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          accept;
  logic          shifting;
  logic          last_bit;

  // Frame state register; reset aborts any frame in flight without a report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and per-cycle outputs; the count saturates instead of wrapping.
  always_comb begin
    state_nxt       = state;
    shifting        = (state == SHIFT);
    in_bus.in_ready = (state == IDLE) & ~reset;
    accept          = in_bus.in_valid & in_bus.in_ready;
    last_bit        = shifting && (idx == IW'(W - 1));
    bit_out         = shifting & shreg[W-1];
    done            = (state == REPORT);
    count_nxt       = (det_out && (count != {CW{1'b1}})) ? count + CW'(1) : count;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit index, running count and the reported count.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      idx     <= '0;
      count   <= '0;
      cnt_out <= '0;
    end else if (accept) begin
      shreg   <= in_bus.in_data;
      idx     <= '0;
      count   <= '0;
      cnt_out <= '0;
    end else if (shifting) begin
      shreg <= {shreg[W-2:0], 1'b0};
      idx   <= idx + IW'(1);
      count <= count_nxt;
      if (last_bit) begin
        cnt_out <= count_nxt;
      end
    end
  end

  // Detector keeps its state across frames unless the accepting word asks for a clean start.
  seq_det_001_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (accept & ~in_bus.carry_en),
    .en    (shifting),
    .inp   (bit_out),
    .det   (det_out)
  );

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Directed bench for the "001" frame scheduler: reset, detection, carry, throughput, abort, saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
// A second instance with CW=1 covers counter saturation.
module tb_seq_det_frame_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_det_frame_ctrl_if #(.W(8)) bus ();
  seq_det_frame_ctrl_if #(.W(8)) bus2 ();

  logic       bit_out, det_out, done;
  logic [3:0] cnt_out;
  logic       bit_out2, det_out2, done2;
  logic [0:0] cnt_out2;

  int vectors     = 0;
  int miscompares = 0;

  seq_det_frame_ctrl #(.W(8), .CW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_bus  (bus),
    .bit_out (bit_out),
    .det_out (det_out),
    .cnt_out (cnt_out),
    .done    (done)
  );

  seq_det_frame_ctrl #(.W(8), .CW(1)) dut_sat (
    .clk     (clk),
    .reset   (reset),
    .in_bus  (bus2),
    .bit_out (bit_out2),
    .det_out (det_out2),
    .cnt_out (cnt_out2),
    .done    (done2)
  );

  // Offers one word, then records 10 cycles of outputs starting at the first SHIFT cycle.
  // dets/bits bit 7 is the first SHIFT cycle; done_pos is the cycle index of the first done.
  task automatic run_frame(input logic [7:0] d, input logic c,
                           output logic [3:0] cnt, output logic [7:0] dets,
                           output logic [7:0] bits, output int rdy_low,
                           output int done_pos, output int done_num);
    int   guard;
    logic rdy_seen;
    bus.in_data  = d;
    bus.carry_en = c;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    dets = '0; bits = '0; cnt = '0;
    rdy_low = 0; done_pos = -1; done_num = 0; rdy_seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        dets[7-j] = det_out;
        bits[7-j] = bit_out;
      end
      if (!rdy_seen && bus.in_ready === 1'b0) rdy_low++;
      else rdy_seen = 1'b1;
      if (done === 1'b1) begin
        done_num++;
        if (done_pos < 0) begin
          done_pos = j;
          cnt = cnt_out;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.carry_en = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.carry_en = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (cnt_out !== 4'd0) begin miscompares++; $display("FAIL reset_cnt_out: got %0d want 0", cnt_out); end
    vectors++; if (bit_out !== 1'b0) begin miscompares++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
    vectors++; if (det_out !== 1'b0) begin miscompares++; $display("FAIL reset_det_out: got %b want 0", det_out); end
    vectors++; if (cnt_out2 !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_out_sat: got %0d want 0", cnt_out2); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_detect();
    logic [3:0] cnt; logic [7:0] dets, bits; int rl, dp, dn;
    run_frame(8'b0010_0100, 1'b0, cnt, dets, bits, rl, dp, dn);
    vectors++; if (dets !== 8'b0010_0100) begin miscompares++; $display("FAIL detect_det_pulses: got %b want 00100100", dets); end
    vectors++; if (bits !== 8'b0010_0100) begin miscompares++; $display("FAIL detect_bit_order: got %b want 00100100", bits); end
    vectors++; if (cnt !== 4'd2) begin miscompares++; $display("FAIL detect_cnt: got %0d want 2", cnt); end
    vectors++; if (dp !== 8) begin miscompares++; $display("FAIL detect_done_pos: got %0d want 8", dp); end
    vectors++; if (dn !== 1) begin miscompares++; $display("FAIL detect_done_width: got %0d want 1", dn); end
    vectors++; if (rl !== 9) begin miscompares++; $display("FAIL detect_ready_low: got %0d want 9", rl); end
    vectors++; if (cnt_out !== 4'd2) begin miscompares++; $display("FAIL detect_cnt_hold: got %0d want 2", cnt_out); end
  endtask

  task automatic test_no_match();
    logic [3:0] cnt; logic [7:0] dets, bits; int rl, dp, dn;
    run_frame(8'hFF, 1'b0, cnt, dets, bits, rl, dp, dn);
    vectors++; if (cnt !== 4'd0 || dp !== 8) begin miscompares++; $display("FAIL ones_cnt: got %0d (done at %0d) want 0 (done at 8)", cnt, dp); end
    vectors++; if (dets !== 8'h00) begin miscompares++; $display("FAIL ones_dets: got %b want 00000000", dets); end
    run_frame(8'h00, 1'b0, cnt, dets, bits, rl, dp, dn);
    vectors++; if (cnt !== 4'd0 || dp !== 8) begin miscompares++; $display("FAIL zeros_cnt: got %0d (done at %0d) want 0 (done at 8)", cnt, dp); end
    vectors++; if (dets !== 8'h00) begin miscompares++; $display("FAIL zeros_dets: got %b want 00000000", dets); end
  endtask

  task automatic test_carry();
    logic [3:0] cnt; logic [7:0] dets, bits; int rl, dp, dn;
    run_frame(8'h00, 1'b0, cnt, dets, bits, rl, dp, dn);
    run_frame(8'h80, 1'b1, cnt, dets, bits, rl, dp, dn);
    vectors++; if (cnt !== 4'd1) begin miscompares++; $display("FAIL carry_on_cnt: got %0d want 1", cnt); end
    vectors++; if (dets !== 8'h80) begin miscompares++; $display("FAIL carry_on_dets: got %b want 10000000", dets); end
    run_frame(8'h00, 1'b0, cnt, dets, bits, rl, dp, dn);
    run_frame(8'h80, 1'b0, cnt, dets, bits, rl, dp, dn);
    vectors++; if (cnt !== 4'd0 || dp !== 8) begin miscompares++; $display("FAIL carry_off_cnt: got %0d (done at %0d) want 0 (done at 8)", cnt, dp); end
    vectors++; if (dets !== 8'h00) begin miscompares++; $display("FAIL carry_off_dets: got %b want 00000000", dets); end
  endtask

  task automatic test_back_to_back();
    int acc1 = -1, acc2 = -1, ndone = 0;
    logic [3:0] dcnt [2];
    dcnt[0] = 4'hF; dcnt[1] = 4'hF;
    bus.in_data = 8'b0010_0100; bus.carry_en = 1'b0; bus.in_valid = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (acc1 >= 0 && n == acc1 + 1) bus.in_data = 8'h20;
      if (acc2 >= 0 && n == acc2 + 1) bus.in_valid = 1'b0;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        if (acc1 < 0) acc1 = n;
        else if (acc2 < 0) acc2 = n;
      end
      if (done === 1'b1) begin
        if (ndone < 2) dcnt[ndone] = cnt_out;
        ndone++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    vectors++; if (acc1 < 0 || acc2 - acc1 !== 10) begin miscompares++; $display("FAIL b2b_spacing: accepts at %0d and %0d, want 10 apart", acc1, acc2); end
    vectors++; if (ndone !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    vectors++; if (dcnt[0] !== 4'd2) begin miscompares++; $display("FAIL b2b_first_cnt: got %0d want 2", dcnt[0]); end
    vectors++; if (dcnt[1] !== 4'd1) begin miscompares++; $display("FAIL b2b_second_cnt: got %0d want 1", dcnt[1]); end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] cnt; logic [7:0] dets, bits; int rl, dp, dn;
    int guard = 0, ndone = 0;
    bus.in_data = 8'b0010_0100; bus.carry_en = 1'b0; bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < 30) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_in_ready_in_reset: got %b want 0", bus.in_ready); end
    vectors++; if (bit_out !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_outputs: bit_out=%b done=%b want 0 0", bit_out, done); end
    vectors++; if (cnt_out !== 4'd0) begin miscompares++; $display("FAIL abort_cnt_out: got %0d want 0", cnt_out); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready_after: got %b want 1", bus.in_ready); end
    for (int n = 0; n < 10; n++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d done pulses want 0", ndone); end
    run_frame(8'h20, 1'b0, cnt, dets, bits, rl, dp, dn);
    vectors++; if (cnt !== 4'd1 || dp !== 8) begin miscompares++; $display("FAIL abort_next_frame_cnt: got %0d (done at %0d) want 1 (done at 8)", cnt, dp); end
  endtask

  task automatic test_saturation();
    int guard = 0;
    bus2.in_data = 8'b0010_0100; bus2.carry_en = 1'b0; bus2.in_valid = 1'b1;
    while (bus2.in_ready !== 1'b1 && guard < 30) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    guard = 0;
    while (done2 !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    vectors++;
    if (done2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_done_timeout: done=%b after %0d cycles, required 1", done2, guard);
    end else if (cnt_out2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_cnt: got %0d want 1", cnt_out2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_detect();
    test_no_match();
    test_carry();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
